// File: rtl/press_classifier.sv
// Gesture classifier: turns press pulses plus the debounced level into
// single-tap / double-tap / long-press pulses and a sticky last-gesture code.
module press_classifier #(
    parameter int LONG_HOLD  = 50_000_000,
    parameter int DOUBLE_WIN = 25_000_000,
    parameter int CNT_W      = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       press_pulse,
    input  logic       press_level,
    output logic       single_tap,
    output logic       double_tap,
    output logic       long_press,
    output logic [1:0] last_event,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD1   = 2'd1,
        WAIT2   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_HOLD - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DOUBLE_WIN - 1);

    localparam logic [1:0] EV_SINGLE = 2'b01;
    localparam logic [1:0] EV_DOUBLE = 2'b10;
    localparam logic [1:0] EV_LONG   = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             single_q, single_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic [1:0]       last_q, last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            last_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
            last_q   <= last_d;
        end
    end

    // Every transition clears the counter, so each state times from its own entry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                if (press_pulse) begin
                    state_d = HELD1;
                    cnt_d   = '0;
                end
            end
            HELD1: begin
                if (!press_level) begin
                    state_d = WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                    last_d  = EV_LONG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT2: begin
                if (press_pulse) begin
                    state_d  = RELEASE;
                    cnt_d    = '0;
                    double_d = 1'b1;
                    last_d   = EV_DOUBLE;
                end else if (cnt_q == DBL_LAST) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    single_d = 1'b1;
                    last_d   = EV_SINGLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                // Wait out the held button so a lingering press cannot start a new gesture.
                if (!press_level) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign single_tap = single_q;
    assign double_tap = double_q;
    assign long_press = long_q;
    assign last_event = last_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_press_classifier.sv
// Directed-vector bench for press_classifier with LONG_HOLD=8, DOUBLE_WIN=6;
// each tick drives one edge's inputs and samples outputs 1 ns after the edge.
`timescale 1ns/1ps
module tb_press_classifier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       press_pulse;
    logic       press_level;
    logic       single_tap;
    logic       double_tap;
    logic       long_press;
    logic [1:0] last_event;
    logic       busy;

    int err_cnt = 0;
    int chk_cnt = 0;
    int n_single, n_double, n_long;

    press_classifier #(
        .LONG_HOLD (8),
        .DOUBLE_WIN(6),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .press_pulse(press_pulse),
        .press_level(press_level),
        .single_tap (single_tap),
        .double_tap (double_tap),
        .long_press (long_press),
        .last_event (last_event),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_single = 0;
        n_double = 0;
        n_long   = 0;
    endtask

    // Drive inputs for one edge, let it happen, sample 1 ns later.
    task automatic tick(input logic pp, input logic pl);
        press_pulse = pp;
        press_level = pl;
        @(posedge clk);
        #1;
        n_single += int'(single_tap);
        n_double += int'(double_tap);
        n_long   += int'(long_press);
    endtask

    initial begin
        rst_n       = 1'b0;
        press_pulse = 1'b0;
        press_level = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_single", 32'(single_tap), 0);
        check("reset_double", 32'(double_tap), 0);
        check("reset_long",   32'(long_press), 0);
        check("reset_last",   32'(last_event), 0);
        check("reset_busy",   32'(busy), 0);
        rst_n = 1'b1;
        tick(0, 0);

        // Single tap: release at edge 3, timeout at edge 9.
        clear_counts();
        tick(1, 1);
        tick(0, 1); tick(0, 1);
        for (int e = 3; e <= 8; e++) tick(0, 0);
        check("st_early_single", 32'(single_tap), 0);
        check("st_busy_e8", 32'(busy), 1);
        tick(0, 0);
        check("st_single_e9", 32'(single_tap), 1);
        check("st_last", 32'(last_event), 1);
        check("st_busy_e9", 32'(busy), 0);
        tick(0, 0);
        check("st_single_e10", 32'(single_tap), 0);
        check("st_n_double", 32'(n_double), 0);
        check("st_n_long", 32'(n_long), 0);
        check("st_n_single", 32'(n_single), 1);
        $display("single tap scenario complete: last_event=%0d", last_event);

        // Double tap: second pulse at edge 6, level held until edge 15.
        clear_counts();
        tick(1, 1);
        tick(0, 1); tick(0, 1);
        tick(0, 0); tick(0, 0); tick(0, 0);
        tick(1, 1);
        check("dt_double_e6", 32'(double_tap), 1);
        check("dt_last", 32'(last_event), 2);
        for (int e = 7; e <= 14; e++) tick(0, 1);
        check("dt_busy_e14", 32'(busy), 1);
        tick(0, 0);
        check("dt_busy_e15", 32'(busy), 0);
        tick(0, 0);
        check("dt_n_single", 32'(n_single), 0);
        check("dt_n_double", 32'(n_double), 1);
        $display("double tap scenario complete: last_event=%0d", last_event);

        // Long press: held to edge 20, stray pulse at edge 12 ignored.
        clear_counts();
        tick(1, 1);
        for (int e = 1; e <= 7; e++) tick(0, 1);
        check("lp_early_long", 32'(long_press), 0);
        tick(0, 1);
        check("lp_long_e8", 32'(long_press), 1);
        check("lp_last", 32'(last_event), 3);
        for (int e = 9; e <= 19; e++) tick(e == 12, 1);
        check("lp_busy_e19", 32'(busy), 1);
        tick(0, 0);
        check("lp_busy_e20", 32'(busy), 0);
        for (int e = 21; e <= 30; e++) tick(0, 0);
        check("lp_n_long", 32'(n_long), 1);
        check("lp_n_single", 32'(n_single), 0);
        check("lp_n_double", 32'(n_double), 0);
        check("lp_last_hold", 32'(last_event), 3);
        $display("long press scenario complete: last_event=%0d", last_event);

        // Boundary: release sampled at edge 8 beats the long-press check.
        clear_counts();
        tick(1, 1);
        for (int e = 1; e <= 7; e++) tick(0, 1);
        tick(0, 0);
        check("b8_no_long", 32'(long_press), 0);
        check("b8_busy", 32'(busy), 1);
        for (int e = 9; e <= 14; e++) tick(0, 0);
        check("b8_single_e14", 32'(single_tap), 1);
        check("b8_last", 32'(last_event), 1);
        check("b8_n_long", 32'(n_long), 0);
        $display("release-at-limit scenario complete: last_event=%0d", last_event);

        // Boundary: second pulse on the timeout edge 9 wins over single tap.
        clear_counts();
        tick(1, 1);
        tick(0, 1); tick(0, 1);
        for (int e = 3; e <= 8; e++) tick(0, 0);
        tick(1, 1);
        check("b9_double", 32'(double_tap), 1);
        check("b9_single", 32'(single_tap), 0);
        check("b9_last", 32'(last_event), 2);
        tick(0, 0);
        check("b9_busy", 32'(busy), 0);
        tick(0, 0);
        check("b9_n_single", 32'(n_single), 0);
        $display("pulse-at-timeout scenario complete: last_event=%0d", last_event);

        // Reset during WAIT2, then a fresh gesture and a back-to-back press.
        clear_counts();
        tick(1, 1);
        tick(0, 0);
        tick(0, 0);
        check("rs_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rs_busy_async", 32'(busy), 0);
        check("rs_last_async", 32'(last_event), 0);
        tick(0, 0);
        tick(0, 0);
        check("rs_single", 32'(single_tap), 0);
        rst_n = 1'b1;
        tick(1, 1);
        check("rs_busy_new", 32'(busy), 1);
        tick(0, 0);
        for (int e = 2; e <= 6; e++) tick(0, 0);
        check("rs_single_e6", 32'(single_tap), 0);
        tick(0, 0);
        check("rs_single_e7", 32'(single_tap), 1);
        check("rs_last", 32'(last_event), 1);
        check("rs_busy_idle", 32'(busy), 0);
        tick(1, 1);
        check("b2b_busy", 32'(busy), 1);
        check("rs_n_single", 32'(n_single), 1);
        check("rs_n_double", 32'(n_double), 0);
        $display("reset scenario complete: last_event=%0d", last_event);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
